// File: rtl/lockin_pkg.sv
// Shared types for the quadrature lock-in detector: FSM state, reference phase, result width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: state_t (IDLE/ACQ/HOLD), phase_t (P0..P3), calc_acc_w().
package lockin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Reference phase within one stimulus period (4 samples per period).
    //   P0: cos=+1   P1: sin=+1   P2: cos=-1   P3: sin=-1
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    // Worst case is 4*(2^PERIODS_W-1) full-scale samples summed into dc.
    // That needs PERIODS_W+2 growth bits on top of the sample width.
    function automatic int calc_acc_w(input int data_w, input int periods_w);
        return data_w + periods_w + 2;
    endfunction

endpackage

// File: rtl/lockin_acc.sv
// Signed accumulator with synchronous clear, enable and add/subtract select.
// Latency: 1 cycle, din reflected in acc on the edge after en.
// Backpressure: none, the accumulator absorbs a value on every enabled cycle.
// Ports: clk, rst (async high), clr, en, sub (1 = subtract), din[W], acc[W].
module lockin_acc import lockin_pkg::*; #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         sub,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - din) : (acc + din);
        end
    end

endmodule

// File: rtl/ac_lockin_detector.sv
// Quadrature lock-in detector: accumulates I/Q correlation and DC sums of 4x-oversampled ADC data.
// Latency: sums and m_valid are registered, visible the cycle after the final sample is accepted.
// Backpressure: result is held in HOLD until m_ready; samples arriving then are dropped and flag overrun.
// Ports: clk, rst (async high), start/periods (request), s_valid/s_data (samples),
//        busy, m_valid/m_ready (result handshake), i_sum, q_sum, dc_sum, overrun (sticky).
// Build option: LOCKIN_DC_EN includes the dc_sum accumulator; otherwise dc_sum is tied to 0.
module ac_lockin_detector import lockin_pkg::*; #(
    parameter  int DATA_W    = 12,
    parameter  int PERIODS_W = 8,
    localparam int ACC_W     = calc_acc_w(DATA_W, PERIODS_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PERIODS_W-1:0] periods,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 busy,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ACC_W-1:0]     i_sum,
    output logic [ACC_W-1:0]     q_sum,
    output logic [ACC_W-1:0]     dc_sum,
    output logic                 overrun
);

    localparam int CNT_W = PERIODS_W + 2;

    state_t           state;
    phase_t           phase;
    logic [CNT_W-1:0] remain;     // samples still to accept in this acquisition

    logic             start_ok;
    logic             accept;
    logic             last;
    logic [ACC_W-1:0] x_ext;

    // A start with periods == 0 would need zero samples; treat it as a no-op.
    assign start_ok = (state == IDLE) && start && (periods != '0);
    assign accept   = (state == ACQ) && s_valid;
    assign last     = (remain == CNT_W'(1));
    assign x_ext    = {{(ACC_W-DATA_W){s_data[DATA_W-1]}}, s_data};

    assign busy    = (state != IDLE);
    assign m_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= P0;
            remain  <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state   <= ACQ;
                        phase   <= P0;
                        remain  <= {periods, 2'b00};
                        overrun <= 1'b0;
                    end
                end
                ACQ: begin
                    if (s_valid) begin
                        phase  <= phase_t'(phase + 2'd1);
                        remain <= remain - CNT_W'(1);
                        if (last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (s_valid) begin
                        overrun <= 1'b1;
                    end
                    // start is deliberately not looked at here; it must be re-issued in IDLE.
                    if (m_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The reference is +1/0/-1/0 and 0/+1/0/-1, so correlation is a steered add/subtract.
    // I takes the even phases, Q the odd ones; phases 2 and 3 subtract.
    logic en_i, en_q, neg;
    assign en_i = accept && ((phase == P0) || (phase == P2));
    assign en_q = accept && ((phase == P1) || (phase == P3));
    assign neg  = (phase == P2) || (phase == P3);

    lockin_acc #(.W(ACC_W)) u_acc_i (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (en_i),
        .sub (neg),
        .din (x_ext),
        .acc (i_sum)
    );

    lockin_acc #(.W(ACC_W)) u_acc_q (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (en_q),
        .sub (neg),
        .din (x_ext),
        .acc (q_sum)
    );

`ifdef LOCKIN_DC_EN
    lockin_acc #(.W(ACC_W)) u_acc_dc (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (accept),
        .sub (1'b0),
        .din (x_ext),
        .acc (dc_sum)
    );
`else
    assign dc_sum = '0;
`endif

endmodule

// File: tb/tb_ac_lockin_detector.sv
// Directed self-checking bench for ac_lockin_detector.
// Latency: n/a (testbench).
// Backpressure: exercised by holding m_ready low in HOLD.
module tb_ac_lockin_detector;

    localparam int DATA_W    = 12;
    localparam int PERIODS_W = 8;
    localparam int ACC_W     = DATA_W + PERIODS_W + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [PERIODS_W-1:0] periods = '0;
    logic                 s_valid = 1'b0;
    logic [DATA_W-1:0]    s_data = '0;
    logic                 busy;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [ACC_W-1:0]     i_sum;
    logic [ACC_W-1:0]     q_sum;
    logic [ACC_W-1:0]     dc_sum;
    logic                 overrun;

    int n_cmp = 0;
    int n_bad = 0;

    ac_lockin_detector dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .periods (periods),
        .s_valid (s_valid),
        .s_data  (s_data),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .i_sum   (i_sum),
        .q_sum   (q_sum),
        .dc_sum  (dc_sum),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected dc value depends on whether the dc accumulator is built in.
    function automatic longint dc_exp(input longint v);
`ifdef LOCKIN_DC_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic do_start(input int p, input bit with_sample);
        start   = 1'b1;
        periods = PERIODS_W'(p);
        s_valid = with_sample;
        s_data  = 12'(999);
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic feed_one(input int x, input int gap);
        s_valid = 1'b1;
        s_data  = 12'(x);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic handshake(input string tag);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_mvalid_drop"}, m_valid, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    task automatic sums(input string tag, input longint ei, input longint eq, input longint ed);
        chk({tag, "_i"}, $signed(i_sum), ei);
        chk({tag, "_q"}, $signed(q_sum), eq);
        chk({tag, "_dc"}, $signed(dc_sum), dc_exp(ed));
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_overrun", overrun, 0);
        sums("rst", 0, 0, 0);

        // Samples in IDLE are ignored and do not flag overrun
        feed_one(55, 0);
        chk("idle_overrun", overrun, 0);
        chk("idle_i", $signed(i_sum), 0);

        // Basic correlation
        do_start(1, 1'b0);
        chk("t1_busy", busy, 1);
        feed_one(100, 0);
        feed_one(0, 0);
        feed_one(-100, 0);
        chk("t1_mvalid_early", m_valid, 0);
        feed_one(0, 0);
        chk("t1_mvalid", m_valid, 1);
        sums("t1", 200, 0, 0);
        handshake("t1");
        chk("t1_hold_idle_i", $signed(i_sum), 200);

        // Mixed phases; a sample on the start cycle must be ignored
        do_start(1, 1'b1);
        chk("t2_cleared_i", $signed(i_sum), 0);
        feed_one(10, 0);
        feed_one(20, 0);
        feed_one(30, 0);
        feed_one(40, 0);
        chk("t2_mvalid", m_valid, 1);
        sums("t2", -20, -20, 100);

        // Backpressure with samples arriving in HOLD
        s_valid = 1'b1;
        s_data  = 12'(777);
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        chk("bp_mvalid", m_valid, 1);
        chk("bp_overrun", overrun, 1);
        sums("bp", -20, -20, 100);
        handshake("bp");
        chk("bp_overrun_sticky", overrun, 1);

        // start with periods = 0 is ignored
        do_start(0, 1'b0);
        chk("p0_busy", busy, 0);
        chk("p0_overrun", overrun, 1);

        // Pure DC with gaps; new start clears overrun
        do_start(2, 1'b0);
        chk("t3_overrun_clr", overrun, 0);
        for (int k = 0; k < 8; k++) begin
            feed_one(500, $urandom_range(0, 3));
        end
        chk("t3_mvalid", m_valid, 1);
        sums("t3", 0, 0, 4000);
        handshake("t3");

        // Full scale, longest acquisition
        do_start(255, 1'b0);
        for (int k = 0; k < 1020; k++) begin
            feed_one((k % 4 == 0) ? 2047 : ((k % 4 == 2) ? -2048 : 0), 0);
        end
        chk("t4_mvalid", m_valid, 1);
        sums("t4", 1044225, 0, -255);
        handshake("t4");

        // start coincident with the HOLD handshake is ignored
        do_start(1, 1'b0);
        feed_one(1, 0);
        feed_one(2, 0);
        feed_one(3, 0);
        feed_one(4, 0);
        sums("t8", -2, -2, 10);
        start   = 1'b1;
        periods = PERIODS_W'(1);
        m_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b0;
        chk("t8_mvalid", m_valid, 0);
        chk("t8_busy", busy, 0);
        @(negedge clk);
        chk("t8_busy_later", busy, 0);

        // Reset mid-acquisition
        do_start(1, 1'b0);
        feed_one(7, 0);
        feed_one(8, 0);
        feed_one(9, 0);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        sums("rstmid", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mvalid", m_valid, 0);
        chk("rstmid_overrun", overrun, 0);

        // Phase restarts at 0 after the abort
        do_start(1, 1'b0);
        feed_one(10, 0);
        feed_one(20, 0);
        feed_one(30, 0);
        feed_one(40, 0);
        chk("t9_mvalid", m_valid, 1);
        sums("t9", -20, -20, 100);
        handshake("t9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ac_lockin_detector.md
# ac_lockin_detector

Digital quadrature lock-in detector: the receiving end of an AC small-signal stimulus. It consumes ADC samples of a circuit node taken at exactly 4× the stimulus frequency and accumulates in-phase (I) and quadrature (Q) correlation sums over a programmable number of stimulus periods. It also accumulates the DC operating-point sum. Results are presented on a valid/ready output port. The block sits between the ADC capture front end and the measurement readout logic, mirroring a DC + AC analysis of the same node.

## Interface
Parameters:
- DATA_W, 12, signed sample width.
- PERIODS_W, 8, width of the period-count request.
- ACC_W, DATA_W+PERIODS_W+2, accumulator and result width; this is fixed, not user-set.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an acquisition.
- periods  in  PERIODS_W  number of stimulus periods; sampled with start.
- s_valid  in  1  sample strobe.
- s_data  in  DATA_W  signed sample.
- busy  out  1  high in ACQ and HOLD.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- i_sum  out  ACC_W  signed I correlation sum.
- q_sum  out  ACC_W  signed Q correlation sum.
- dc_sum  out  ACC_W  signed sample sum.
- overrun  out  1  sticky: a sample arrived while the block was in HOLD.

## Operation
- States: IDLE, ACQ, HOLD.
- IDLE → ACQ: on start with periods ≠ 0.
  - Clears the accumulators, the 2-bit phase counter and overrun.
  - Loads the sample target 4×periods.
  - start with periods = 0 is ignored; the block stays in IDLE.
- ACQ: each cycle with s_valid high, the sample is accepted and the phase counter advances modulo 4.
  - Phase 0: I += x.
  - Phase 1: Q += x.
  - Phase 2: I −= x.
  - Phase 3: Q −= x.
  - The reference is therefore cos = +1, 0, −1, 0 and sin = 0, +1, 0, −1. No multipliers are used.
  - dc += x on every accepted sample (when dc is compiled in).
- ACQ → HOLD: on the edge that accepts the final (4×periods-th) sample.
- HOLD: outputs are frozen and m_valid = 1.
  - If s_valid is high, the sample is dropped and overrun is set.
  - When m_valid && m_ready: go to IDLE and drop m_valid.
- start is ignored in ACQ and HOLD, including a start coincident with the HOLD handshake; it must be re-issued in IDLE.
- Samples arriving in IDLE are discarded silently and do not set overrun.
- Arithmetic is two's complement, with samples sign-extended to ACC_W. ACC_W is sized so that no overflow can occur at full scale with periods = 2^PERIODS_W − 1.

## Timing
- Reset values: busy = 0, m_valid = 0, i_sum = q_sum = dc_sum = 0, overrun = 0, state = IDLE, phase = 0.
- busy rises on the cycle after start is accepted.
- A sample presented on the cycle of start is not accepted.
- Latency: m_valid and the final sums are visible the cycle after the last sample is accepted. They are registered outputs.
- i_sum, q_sum and dc_sum change only in ACQ. They hold the previous result through IDLE until the next start clears them.
- Back-to-back acquisitions take at least 1 IDLE cycle between the handshake and the next start.
- Reset asserted mid-ACQ or mid-HOLD aborts immediately to the reset values. The partial result is lost.

## Configuration
- LOCKIN_DC_EN defined: the dc_sum accumulator is present and updated as above.
- LOCKIN_DC_EN undefined: the accumulator is removed and dc_sum is tied to 0. All other behaviour is identical.

## Structure
- lockin_pkg holds:
  - the state enum (IDLE/ACQ/HOLD);
  - the phase enum (P0..P3);
  - a constant function for ACC_W from DATA_W and PERIODS_W.
- Sub-module lockin_acc: signed accumulator with synchronous clear, enable and add/subtract select.
  - Instantiated for I and Q.
  - A third instance for dc exists only under LOCKIN_DC_EN.
- Top level: state machine, phase counter, sample-target counter, overrun flag.

## Test plan
- Basic correlation: periods = 1, samples 100, 0, −100, 0 → i_sum = 200, q_sum = 0, dc_sum = 0; m_valid high 1 cycle after the 4th sample.
- Mixed phases: periods = 1, samples 10, 20, 30, 40 → i_sum = −20, q_sum = −20, dc_sum = 100 (0 without LOCKIN_DC_EN).
- Pure DC with gappy s_valid: periods = 2, eight samples of 500 with random idle cycles between them → i_sum = q_sum = 0, dc_sum = 4000.
- Full scale: periods = 255; +2047 at phase 0, −2048 at phase 2, 0 elsewhere → i_sum = 1044225, q_sum = 0, no wrap.
- Backpressure: m_ready held low for 5 cycles in HOLD with s_valid high → sums unchanged, overrun = 1. The handshake then returns the block to IDLE. The next start clears overrun.
- Control corner cases:
  - start with periods = 0 → busy stays 0.
  - rst pulse after 3 samples of an acquisition → all outputs 0, state IDLE.
  - start coincident with the HOLD handshake → ignored.
